dm_store_buffer: RTL

- Sits between the CPU data-memory port (EX-stage address/data, MEM-stage read data) and the single-port data SRAM controller.
- Absorbs stores into a small FIFO so stores do not block the pipeline; drains them to memory when the port is idle.
- Loads take priority on the port; load data is merged with younger buffered store bytes (bit-masked) so the CPU always sees program-order data.
- Drives a stall back to the CPU hazard logic when a request cannot be accepted.

---
 rtl/dm_store_buffer_if.sv | 28 ++
 rtl/dm_store_buffer.sv | 92 +++++++++
 2 files changed

// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: CPU data port and SRAM controller port of the store buffer
interface dm_store_buffer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_wbe;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wbe;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_wbe, mem_ready, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wbe
  );
  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_wbe, mem_ready, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wbe
  );
endinterface

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: store FIFO draining to data SRAM with load priority; SB_FORWARD_EN merges buffered store bytes into loads
module dm_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  dm_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DATA_W-1:0] q_wbe  [DEPTH];
  logic [PW-1:0]     head, tail, idx;
  logic [PW:0]       count;
  logic [DATA_W-1:0] rdata_q, merged;
  logic              hit, busy, full, load_port, load_acc, push, pop, acc_q;
`ifdef SB_FORWARD_EN
  logic [DATA_W-1:0] fmask, fdata, fmask_q, fdata_q;
`endif
  // Walk oldest to newest so younger stores overwrite older bits
  always_comb begin
    hit = 1'b0;
    idx = head;
`ifdef SB_FORWARD_EN
    fmask = '0;
    fdata = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) && q_addr[idx] == bus.cpu_addr) begin
        hit = 1'b1;
`ifdef SB_FORWARD_EN
        fmask = fmask | q_wbe[idx];
        fdata = (fdata & ~q_wbe[idx]) | (q_data[idx] & q_wbe[idx]);
`endif
      end
    end
  end
  assign busy = count != '0;
  assign full = count == (PW+1)'(DEPTH);
`ifdef SB_FORWARD_EN
  assign load_port = bus.cpu_re;
  assign merged    = (bus.mem_rdata & ~fmask_q) | (fdata_q & fmask_q);
`else
  assign load_port = bus.cpu_re & ~hit;
  assign merged    = bus.mem_rdata;
`endif
  assign load_acc      = load_port & bus.mem_ready;
  assign push          = bus.cpu_we & ~bus.cpu_re & ~full;
  assign pop           = bus.mem_we & bus.mem_ready;
  assign bus.mem_req   = load_port | busy;
  assign bus.mem_we    = ~load_port & busy;
  assign bus.mem_addr  = load_port ? bus.cpu_addr : q_addr[head];
  assign bus.mem_wdata = q_data[head];
  assign bus.mem_wbe   = q_wbe[head];
  assign bus.cpu_stall = (bus.cpu_we & (bus.cpu_re | full)) | (bus.cpu_re & ~load_acc);
  assign bus.cpu_rdata = acc_q ? merged : rdata_q;
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= bus.cpu_addr;
      q_data[tail] <= bus.cpu_wdata;
      q_wbe[tail]  <= bus.cpu_wbe;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      acc_q   <= 1'b0;
      rdata_q <= '0;
`ifdef SB_FORWARD_EN
      fmask_q <= '0;
      fdata_q <= '0;
`endif
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      acc_q <= load_acc;
      if (acc_q) rdata_q <= merged;
`ifdef SB_FORWARD_EN
      if (load_acc) begin
        fmask_q <= fmask;
        fdata_q <= fdata;
      end
`endif
    end
  end
endmodule
